// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared types and choice decode for the rock/paper/scissors judge
// Purpose: choice, result and FSM state enums plus the one-hot r/p/s decode
// applied when a player's submission is latched.
// Ports: none (package).
package rps_pkg;

  // NONE marks "nothing latched yet"; ILLEGAL is any r/p/s pattern that is not one-hot.
  typedef enum logic [2:0] {
    NONE     = 3'd0,
    ROCK     = 3'd1,
    PAPER    = 3'd2,
    SCISSORS = 3'd3,
    ILLEGAL  = 3'd4
  } choice_t;

  typedef enum logic [1:0] {
    DRAW      = 2'd0,
    P1_WINS   = 2'd1,
    P2_WINS   = 2'd2,
    NO_RESULT = 2'd3
  } result_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    JUDGE   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  function automatic choice_t decode_choice(input logic r, input logic p, input logic s);
    choice_t c;
    case ({r, p, s})
      3'b100:  c = ROCK;
      3'b010:  c = PAPER;
      3'b001:  c = SCISSORS;
      default: c = ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rps_if.sv
// rtl/rps_if.sv - judge channel between the round FSM and the combinational judge
// Ports (modports):
//   master: drives c1/c2 (latched choices), reads result
//   slave : reads c1/c2, drives result
interface rps_if;
  import rps_pkg::*;

  choice_t c1;
  choice_t c2;
  result_t result;

  modport master (output c1, output c2, input result);
  modport slave  (input c1, input c2, output result);

endinterface

// File: rtl/rps_judge.sv
// rtl/rps_judge.sv - combinational mapping of two latched choices to a round result
// Ports:
//   jif (rps_if.slave): c1/c2 choices in, result out
module rps_judge
  import rps_pkg::*;
(
  rps_if.slave jif
);

  function automatic logic beats(input choice_t a, input choice_t b);
    return (a == ROCK     && b == SCISSORS) ||
           (a == SCISSORS && b == PAPER)    ||
           (a == PAPER    && b == ROCK);
  endfunction

  always_comb begin
    jif.result = NO_RESULT;
    if (jif.c1 == NONE || jif.c2 == NONE) begin
      jif.result = NO_RESULT;
    end else if (jif.c1 == ILLEGAL && jif.c2 == ILLEGAL) begin
      jif.result = NO_RESULT;
    end else if (jif.c1 == ILLEGAL) begin
      jif.result = P2_WINS;
    end else if (jif.c2 == ILLEGAL) begin
      jif.result = P1_WINS;
    end else if (jif.c1 == jif.c2) begin
      jif.result = DRAW;
    end else if (beats(jif.c1, jif.c2)) begin
      jif.result = P1_WINS;
    end else begin
      jif.result = P2_WINS;
    end
  end

endmodule

// File: rtl/rps_dut.sv
// rtl/rps_dut.sv - rock/paper/scissors round FSM with saturating score counters
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   r1/p1/s1, go1     : player-1 choice and submit strobe
//   r2/p2/s2, go2     : player-2 choice and submit strobe
//   score1, score2    : registered, saturating win counts
//   dut_busy          : high while a round is judged/held (JUDGE and HOLD)
module rps_dut
  import rps_pkg::*;
#(
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned BUSY_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r1,
  input  logic               p1,
  input  logic               s1,
  input  logic               r2,
  input  logic               p2,
  input  logic               s2,
  input  logic               go1,
  input  logic               go2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               dut_busy
);

  localparam int unsigned        CNT_W     = $clog2(BUSY_CYCLES);
  // HOLD counts down from here to zero, giving BUSY_CYCLES-1 HOLD cycles.
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(BUSY_CYCLES - 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state_q, state_d;
  choice_t            c1_q, c1_d, c2_q, c2_d;
  logic               sub1_q, sub1_d, sub2_q, sub2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  result_t            result;

  rps_if u_jif ();
  assign u_jif.c1 = c1_q;
  assign u_jif.c2 = c2_q;
  assign result   = u_jif.result;

  rps_judge u_judge (.jif(u_jif));

  always_comb begin
    state_d  = state_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    sub1_d   = sub1_q;
    sub2_d   = sub2_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    case (state_q)
      // IDLE always has both flags clear, so it shares COLLECT's logic:
      // only a player not yet submitted may latch, so repeats are dropped.
      IDLE, COLLECT: begin
        if (go1 && !sub1_q) begin
          c1_d   = decode_choice(r1, p1, s1);
          sub1_d = 1'b1;
        end
        if (go2 && !sub2_q) begin
          c2_d   = decode_choice(r2, p2, s2);
          sub2_d = 1'b1;
        end
        if (sub1_d && sub2_d) begin
          state_d = JUDGE;
        end else if (sub1_d || sub2_d) begin
          state_d = COLLECT;
        end
      end
      JUDGE: begin
        state_d = HOLD;
        cnt_d   = HOLD_LAST;
        if (result == P1_WINS && score1_q != SCORE_MAX) begin
          score1_d = score1_q + SCORE_W'(1);
        end
        if (result == P2_WINS && score2_q != SCORE_MAX) begin
          score2_d = score2_q + SCORE_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          sub1_d  = 1'b0;
          sub2_d  = 1'b0;
          c1_d    = NONE;
          c2_d    = NONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      c1_q     <= NONE;
      c2_q     <= NONE;
      sub1_q   <= 1'b0;
      sub2_q   <= 1'b0;
      cnt_q    <= '0;
      score1_q <= '0;
      score2_q <= '0;
    end else begin
      state_q  <= state_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      sub1_q   <= sub1_d;
      sub2_q   <= sub2_d;
      cnt_q    <= cnt_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
    end
  end

  assign score1   = score1_q;
  assign score2   = score2_q;
  assign dut_busy = (state_q == JUDGE) || (state_q == HOLD);

endmodule

// File: tb/tb_rps_dut.sv
// tb/tb_rps_dut.sv - scoreboard bench for rps_dut against a behavioural round model
module tb_rps_dut;
  import rps_pkg::*;

  localparam int SCORE_W = 8;
  localparam int BUSY    = 3;

  logic clk = 1'b0;
  logic rst;
  logic r1, p1, s1, r2, p2, s2, go1, go2;
  logic [SCORE_W-1:0] score1, score2;
  logic dut_busy;

  always #5 clk = ~clk;

  rps_dut #(.SCORE_W(SCORE_W), .BUSY_CYCLES(BUSY)) dut (
    .clk(clk), .rst(rst),
    .r1(r1), .p1(p1), .s1(s1),
    .r2(r2), .p2(p2), .s2(s2),
    .go1(go1), .go2(go2),
    .score1(score1), .score2(score2),
    .dut_busy(dut_busy)
  );

  rps_if tb_if ();
  rps_judge u_judge_chk (.jif(tb_if));

  typedef struct {
    int rise;
    int s1;
    int s2;
    int len;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_s1     = 0;
  int m_s2     = 0;
  int score_max = (1 << SCORE_W) - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: legal choices are 0=rock,1=paper,2=scissors; each beats (itself-1) mod 3.
  function automatic int idx(input logic [2:0] v);
    case (v)
      3'b100:  return 0;
      3'b010:  return 1;
      3'b001:  return 2;
      default: return -1;
    endcase
  endfunction

  // 0 = no change, 1 = player 1 scores, 2 = player 2 scores
  function automatic int winner(input logic [2:0] a, input logic [2:0] b);
    int ia, ib, d;
    ia = idx(a);
    ib = idx(b);
    if (ia < 0 && ib < 0) return 0;
    if (ia < 0) return 2;
    if (ib < 0) return 1;
    d = (ia - ib + 3) % 3;
    return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
  endfunction

  function automatic logic [2:0] rand_choice();
    case ($urandom % 4)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'($urandom);
    endcase
  endfunction

  function automatic logic [2:0] to_vec(input choice_t c);
    case (c)
      ROCK:     return 3'b100;
      PAPER:    return 3'b010;
      SCISSORS: return 3'b001;
      default:  return 3'b111;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_model(input logic [2:0] v1, input logic [2:0] v2);
    int w;
    w = winner(v1, v2);
    if (w == 1 && m_s1 < score_max) m_s1++;
    if (w == 2 && m_s2 < score_max) m_s2++;
  endtask

  // Submit one round; gap = edges between first and second go (0 = simultaneous).
  // With noise, the already-submitted player re-presses with random choices and
  // both players press randomly throughout busy and on the return-to-IDLE edge.
  task automatic play(input logic [2:0] v1, input logic [2:0] v2, input int gap,
                      input bit p2_first, input bit noise);
    if (gap == 0) begin
      {r1, p1, s1} = v1; {r2, p2, s2} = v2;
      go1 = 1'b1; go2 = 1'b1;
      tick();
    end else begin
      if (!p2_first) begin {r1, p1, s1} = v1; go1 = 1'b1; end
      else begin {r2, p2, s2} = v2; go2 = 1'b1; end
      tick();
      for (int i = 1; i < gap; i++) begin
        go1 = 1'b0; go2 = 1'b0;
        if (noise && !p2_first) begin {r1, p1, s1} = 3'($urandom); go1 = 1'($urandom); end
        if (noise &&  p2_first) begin {r2, p2, s2} = 3'($urandom); go2 = 1'($urandom); end
        tick();
      end
      if (!p2_first) begin
        {r2, p2, s2} = v2; go2 = 1'b1;
        go1 = noise ? 1'($urandom) : 1'b0;
        {r1, p1, s1} = noise ? 3'($urandom) : v1;
      end else begin
        {r1, p1, s1} = v1; go1 = 1'b1;
        go2 = noise ? 1'($urandom) : 1'b0;
        {r2, p2, s2} = noise ? 3'($urandom) : v2;
      end
      tick();
    end
    apply_model(v1, v2);
    sb.push_back('{cyc, m_s1, m_s2, BUSY});
    for (int i = 0; i < BUSY; i++) begin
      go1 = noise ? 1'($urandom) : 1'b0;
      go2 = noise ? 1'($urandom) : 1'b0;
      {r1, p1, s1} = 3'($urandom);
      {r2, p2, s2} = 3'($urandom);
      tick();
    end
    go1 = 1'b0; go2 = 1'b0;
  endtask

  // Monitor: each busy pulse pops one expectation; checks rise cycle, scores
  // in the second busy cycle, and pulse length.
  logic prev_busy = 1'b0;
  int   mon_cnt   = 0;
  bit   have_cur  = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (dut_busy === 1'b1 && prev_busy !== 1'b1) begin
      mon_cnt = 1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        have_cur = 1'b0;
        $display("FAIL unexpected_busy actual=busy_at_cycle_%0d required=no_round_pending", cyc);
      end else begin
        cur = sb.pop_front();
        have_cur = 1'b1;
        check("busy_rise_cycle", cyc, cur.rise);
      end
    end else if (dut_busy === 1'b1) begin
      mon_cnt++;
      if (mon_cnt == 2 && have_cur) begin
        check("score1_after_round", score1, cur.s1);
        check("score2_after_round", score2, cur.s2);
      end
    end else if (prev_busy === 1'b1 && have_cur) begin
      check("busy_len", mon_cnt, cur.len);
      have_cur = 1'b0;
    end
    prev_busy = dut_busy;
  end

  initial begin
    logic [2:0] pw1[3];
    logic [2:0] pw2[3];
    result_t r_act, r_exp;
    int k;
    pw1[0] = 3'b100; pw2[0] = 3'b010;
    pw1[1] = 3'b010; pw2[1] = 3'b001;
    pw1[2] = 3'b001; pw2[2] = 3'b100;

    rst = 1'b1;
    {r1, p1, s1, r2, p2, s2, go1, go2} = '0;
    tb_if.c1 = NONE;
    tb_if.c2 = NONE;
    tick();
    tick();
    check("reset_score1", score1, 0);
    check("reset_score2", score2, 0);
    check("reset_busy", dut_busy, 0);

    // First go accepted on the first edge after reset release.
    rst = 1'b0;
    play(3'b100, 3'b001, 0, 1'b0, 1'b0);
    play(3'b010, 3'b100, 4, 1'b0, 1'b0);
    play(3'b001, 3'b001, 0, 1'b0, 1'b0);
    play(3'b010, 3'b110, 0, 1'b0, 1'b0);
    play(3'b100, 3'b010, 3, 1'b0, 1'b1);
    play(3'b001, 3'b010, 2, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      play(rand_choice(), rand_choice(), int'($urandom % 5), 1'($urandom), 1'b1);
    end

    // Reset mid-HOLD after reaching 3/2: round aborts after two busy cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_s1 = 0; m_s2 = 0;
    for (int i = 0; i < 3; i++) play(3'b100, 3'b001, 0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) play(3'b001, 3'b100, 1, 1'b0, 1'b0);
    {r1, p1, s1} = 3'b010; {r2, p2, s2} = 3'b010;
    go1 = 1'b1; go2 = 1'b1;
    tick();
    go1 = 1'b0; go2 = 1'b0;
    sb.push_back('{cyc, 3, 2, 2});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_s1 = 0; m_s2 = 0;
    check("abort_score1", score1, 0);
    check("abort_score2", score2, 0);
    check("abort_busy", dut_busy, 0);
    play(3'b001, 3'b010, 0, 1'b0, 1'b0);

    // Saturation of player 2.
    for (int i = 0; i < 260; i++) begin
      k = int'($urandom % 3);
      play(pw1[k], pw2[k], 0, 1'b0, 1'b0);
    end
    check("score2_saturated", score2, score_max);

    // Stand-alone judge over every legal/illegal choice pair.
    for (int a = 1; a <= 4; a++) begin
      for (int b = 1; b <= 4; b++) begin
        tb_if.c1 = choice_t'(3'(a));
        tb_if.c2 = choice_t'(3'(b));
        #1;
        case (winner(to_vec(tb_if.c1), to_vec(tb_if.c2)))
          1:       r_exp = P1_WINS;
          2:       r_exp = P2_WINS;
          default: r_exp = DRAW;
        endcase
        r_act = tb_if.result;
        // Both illegal may be reported as either DRAW or NO_RESULT; neither scores.
        if (a == 4 && b == 4 && r_act == NO_RESULT) r_act = DRAW;
        check("judge_result", r_act, r_exp);
      end
    end

    for (int i = 0; i < 50 && (sb.size() != 0 || have_cur); i++) tick();
    tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rps_dut.md
RPS_DUT -- requirements
Module: rps_dut

Interface
REQ-001 SHALL have parameter SCORE_W, default 8: width of each score counter.
REQ-002 SHALL have parameter BUSY_CYCLES, default 3: cycles dut_busy stays high per round; legal values are 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports r1, p1, s1, input, 1 bit each: player-1 rock/paper/scissors choice; legal when exactly one is high.
REQ-006 SHALL have ports r2, p2, s2, input, 1 bit each: player-2 choice, same encoding as player 1.
REQ-007 SHALL have ports go1 and go2, input, 1 bit each: player submits the current r/p/s on this edge.
REQ-008 SHALL have ports score1 and score2, output, SCORE_W bits each: registered win counts.
REQ-009 SHALL have port dut_busy, output, 1 bit: round being judged; go inputs are ignored while it is high.

Function
REQ-010 SHALL implement the FSM states IDLE, COLLECT, JUDGE and HOLD.
REQ-011 IDLE: a go from either player latches that player's r/p/s and sets that player's "submitted" flag.
REQ-012 IDLE transition: go from one player only -> COLLECT; go1 and go2 in the same cycle -> JUDGE.
REQ-013 COLLECT: waits for the missing player's go, latches that choice, then -> JUDGE.
REQ-014 COLLECT: a repeat go from a player already submitted SHALL be ignored; the first choice stands.
REQ-015 dut_busy SHALL be high in JUDGE and HOLD only, for exactly BUSY_CYCLES consecutive cycles, starting the cycle after the edge that completed both submissions.
REQ-016 JUDGE (one cycle): the winner is decided; the winner's score is updated on the JUDGE->HOLD edge, so the new value is visible in the second busy cycle.
REQ-017 Win rules: rock beats scissors, scissors beats paper, paper beats rock; an identical choice is a draw with no score change.
REQ-018 Illegal choice (not one-hot): a player whose latched choice is illegal loses to a legal opponent; if both are illegal, no score changes.
REQ-019 Scores SHALL saturate at 2^SCORE_W-1 and never wrap.
REQ-020 HOLD SHALL last BUSY_CYCLES-1 cycles, then -> IDLE with the submitted flags cleared.
REQ-021 go1 and go2 SHALL be ignored in JUDGE and HOLD; no queuing.
REQ-022 A go asserted on the same edge the FSM returns to IDLE SHALL be ignored; it is accepted from the next edge.
REQ-023 Scores SHALL accumulate across rounds and clear only on reset.

Reset
REQ-024 While rst=1 at a clk edge: state IDLE, score1=0, score2=0, dut_busy=0, latched choices and submitted flags cleared.
REQ-025 Reset asserted mid-round (COLLECT, JUDGE or HOLD) SHALL abort the round with no score update.
REQ-026 The first go SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-027 A shared package rps_pkg SHALL hold the choice enum (NONE, ROCK, PAPER, SCISSORS, ILLEGAL), the result enum (DRAW, P1_WINS, P2_WINS, NO_RESULT), the FSM state enum, and a one-hot-to-choice decode function.
REQ-028 One combinational sub-module rps_judge SHALL map two choices to a result; the FSM, latches, counters and busy timer SHALL sit in rps_dut.

Verification
REQ-029 Reset then both players submitted simultaneously (r1=1, s2=1 with go1=go2=1 for one cycle) -> dut_busy high for exactly 3 cycles; score1=1 from the second busy cycle; score2=0.
REQ-030 Staggered submission (go1 with p1 at cycle 0, go2 with r2 at cycle 4) -> dut_busy rises at cycle 5; score1 increments by 1.
REQ-031 Draw (s1=s2=1) -> busy pulse of 3 cycles with both scores unchanged; illegal r2=p2=1 against legal p1 -> score1 increments by 1.
REQ-032 go pulses during busy and a repeated go1 in COLLECT -> ignored; the first choice decides the round.
REQ-033 Drive 260 player-2 wins with SCORE_W=8 -> score2 holds at 255.
REQ-034 rst asserted in HOLD after scores reach 3/2 -> next cycle both scores are 0, dut_busy=0, state IDLE.
